// File: rtl/board_loader.sv
`default_nettype none
// ============================================================================
// Module   : board_loader
// Purpose  : Operator row-entry stage for the Game of Life board: debounced
//            cursor stepping, centre-button row commit and bulk-clear sweep.
//            Build option: define WRAP_EN for cursor wrap-around.
// Revision : 1.0  initial release
// ============================================================================
module board_loader #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int DB_CYCLES = 250000,
    parameter int RW        = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_center,
    input  logic                 clear_req,
    input  logic [COLS-1:0]      sw,
    output logic [RW-1:0]        cursor,
    output logic [ROWS*COLS-1:0] board,
    output logic                 row_wr,
    output logic                 busy,
    output logic                 ready
);

    localparam int             CW         = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  c_DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [RW-1:0]  c_LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EDIT  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    logic [2:0] w_btn_raw;
    wire  [2:0] w_press;
    logic       w_up;
    logic       w_down;
    logic       w_center;

    assign w_btn_raw = {btn_center, btn_down, btn_up};
    assign w_up      = w_press[0];
    assign w_down    = w_press[1];
    assign w_center  = w_press[2];

    // Press fires on the same edge the debounced level would rise, so the
    // action lands DB_CYCLES+2 clocks after the raw rise.
    generate
        for (genvar b = 0; b < 3; b++) begin : g_btn
            logic          r_sync1;
            logic          r_sync2;
            logic          r_db;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn_raw[b];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_cnt <= '0;
                        r_db  <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            assign w_press[b] = r_sync2 & ~r_db & (r_cnt == c_DB_LAST);
        end
    endgenerate

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [RW-1:0]               r_cursor;
    logic [RW-1:0]               w_cursor_nxt;
    logic [RW-1:0]               r_k;
    logic [RW-1:0]               w_k_nxt;
    logic                        r_row_wr;
    logic                        w_row_wr_nxt;
    logic                        w_wr_en;
    logic [RW-1:0]               w_wr_row;
    logic [COLS-1:0]             w_wr_data;
    logic [ROWS-1:0][COLS-1:0]   r_board;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cursor <= '0;
            r_k      <= '0;
            r_row_wr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cursor <= w_cursor_nxt;
            r_k      <= w_k_nxt;
            r_row_wr <= w_row_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        w_k_nxt      = r_k;
        w_row_wr_nxt = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_row     = r_cursor;
        w_wr_data    = sw;

        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_k_nxt     = '0;
                end else if (enable) begin
                    w_state_nxt = S_EDIT;
                end
            end

            S_EDIT: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_k_nxt     = '0;
                end else if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    // Write uses the pre-move cursor; the move lands on the same edge.
                    if (w_center) begin
                        w_wr_en      = 1'b1;
                        w_row_wr_nxt = 1'b1;
                    end
                    if (w_up && !w_down) begin
                        if (r_cursor != '0)
                            w_cursor_nxt = r_cursor - RW'(1);
`ifdef WRAP_EN
                        else
                            w_cursor_nxt = c_LAST_ROW;
`endif
                    end else if (w_down && !w_up) begin
                        if (r_cursor != c_LAST_ROW)
                            w_cursor_nxt = r_cursor + RW'(1);
`ifdef WRAP_EN
                        else
                            w_cursor_nxt = '0;
`endif
                    end
                end
            end

            S_CLEAR: begin
                w_wr_en   = 1'b1;
                w_wr_row  = r_k;
                w_wr_data = '0;
                if (r_k == c_LAST_ROW) begin
                    w_k_nxt      = '0;
                    w_cursor_nxt = '0;
                    w_row_wr_nxt = 1'b1;
                    w_state_nxt  = enable ? S_EDIT : S_IDLE;
                end else begin
                    w_k_nxt = r_k + RW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board <= '0;
        end else if (w_wr_en) begin
            r_board[w_wr_row] <= w_wr_data;
        end
    end

    assign cursor = r_cursor;
    assign board  = r_board;
    assign row_wr = r_row_wr;
    assign busy   = (r_state == S_CLEAR);
    assign ready  = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_board_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_loader
// Purpose  : Scoreboard bench for board_loader (ROWS=COLS=16, DB_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_board_loader;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int DB   = 4;
    localparam int RW   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_center;
    logic                 clear_req;
    logic [COLS-1:0]      sw;
    logic [RW-1:0]        cursor;
    logic [ROWS*COLS-1:0] board;
    logic                 row_wr;
    logic                 busy;
    logic                 ready;

    always #5 clk = ~clk;

    board_loader #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .DB_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_center (btn_center),
        .clear_req  (clear_req),
        .sw         (sw),
        .cursor     (cursor),
        .board      (board),
        .row_wr     (row_wr),
        .busy       (busy),
        .ready      (ready)
    );

    // row < 0 marks a whole-board clear
    typedef struct {
        int              row;
        logic [COLS-1:0] data;
    } exp_t;

    exp_t                 sb_q[$];
    exp_t                 mon_e;
    int                   checks = 0;
    int                   errors = 0;
    int                   exp_cursor = 0;
    logic [ROWS*COLS-1:0] exp_board = '0;

    function automatic int model_move(input int cur, input bit up, input bit dn);
        int r;
        r = cur;
        if (up && !dn) begin
            if (cur > 0) r = cur - 1;
`ifdef WRAP_EN
            else r = ROWS - 1;
`endif
        end else if (dn && !up) begin
            if (cur < ROWS - 1) r = cur + 1;
`ifdef WRAP_EN
            else r = 0;
`endif
        end
        return r;
    endfunction

    // Every row_wr pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && row_wr) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL row_wr_unexpected: row_wr=1 got, none pending required (cursor=%0d)", cursor);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.row < 0) begin
                    if (board !== '0) begin
                        errors++;
                        $display("FAIL clear_board: got %h, required 0", board);
                    end
                end else if (board[mon_e.row*COLS +: COLS] !== mon_e.data) begin
                    errors++;
                    $display("FAIL row_write[%0d]: got %h, required %h",
                             mon_e.row, board[mon_e.row*COLS +: COLS], mon_e.data);
                end
            end
        end
    end

    task automatic press(input bit up, input bit dn, input bit ctr);
        @(negedge clk);
        btn_up = up; btn_down = dn; btn_center = ctr;
        repeat (DB + 4) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic do_press(input bit up, input bit dn, input bit ctr);
        exp_t e;
        if (ctr) begin
            e.row  = exp_cursor;
            e.data = sw;
            sb_q.push_back(e);
            exp_board[exp_cursor*COLS +: COLS] = sw;
        end
        exp_cursor = model_move(exp_cursor, up, dn);
        press(up, dn, ctr);
    endtask

    task automatic goto_row(input int target);
        for (int i = 0; i < 2*ROWS && exp_cursor != target; i++)
            do_press(exp_cursor > target, exp_cursor < target, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        btn_center = 1'b0; clear_req = 1'b0; sw = '0;
        repeat (3) @(negedge clk);
        checks++; if (cursor !== '0)   begin errors++; $display("FAIL reset_cursor: got %0d, required 0", cursor); end
        checks++; if (board !== '0)    begin errors++; $display("FAIL reset_board: got %h, required 0", board); end
        checks++; if (row_wr !== 1'b0) begin errors++; $display("FAIL reset_row_wr: got %b, required 0", row_wr); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_debounce;
        exp_t e;
        int   first;
        int   n;
        enable = 1'b1; sw = 16'hA5C3;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL edit_ready: got %b, required 0", ready); end
        e.row = 0; e.data = 16'hA5C3;
        sb_q.push_back(e);
        exp_board[15:0] = 16'hA5C3;
        btn_center = 1'b1; @(negedge clk);
        btn_center = 1'b0; @(negedge clk);
        btn_center = 1'b1;
        first = 0; n = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (row_wr) begin
                n++;
                if (first == 0) first = i;
            end
        end
        checks++; if (first != DB + 2) begin errors++; $display("FAIL debounce_latency: got %0d clocks, required %0d", first, DB + 2); end
        checks++; if (n != 1)          begin errors++; $display("FAIL debounce_row_wr_count: got %0d, required 1", n); end
        repeat (6) @(negedge clk);
        btn_center = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic test_cursor;
        repeat (3) do_press(1'b0, 1'b1, 1'b0);
        checks++; if (cursor !== 4'd3) begin errors++; $display("FAIL cursor_step: got %0d, required 3", cursor); end
        sw = 16'h0F0F;
        do_press(1'b0, 1'b0, 1'b1);
        checks++; if (board[63:48] !== 16'h0F0F) begin errors++; $display("FAIL row3_data: got %h, required 0f0f", board[63:48]); end
        checks++; if (board !== exp_board)       begin errors++; $display("FAIL board_after_row3: got %h, required %h", board, exp_board); end
    endtask

    task automatic test_boundary;
        goto_row(0);
        checks++; if (cursor !== 4'd0) begin errors++; $display("FAIL goto_zero: got %0d, required 0", cursor); end
        do_press(1'b1, 1'b0, 1'b0);
        checks++; if (cursor !== RW'(exp_cursor)) begin errors++; $display("FAIL up_at_zero: got %0d, required %0d", cursor, exp_cursor); end
        goto_row(ROWS - 1);
        checks++; if (cursor !== 4'd15) begin errors++; $display("FAIL goto_last: got %0d, required 15", cursor); end
        do_press(1'b0, 1'b1, 1'b0);
        checks++; if (cursor !== RW'(exp_cursor)) begin errors++; $display("FAIL down_at_last: got %0d, required %0d", cursor, exp_cursor); end
    endtask

    task automatic test_simultaneous;
        goto_row(5);
        sw = 16'h8001;
        do_press(1'b0, 1'b1, 1'b1);
        checks++; if (cursor !== 4'd6)             begin errors++; $display("FAIL ctr_down_cursor: got %0d, required 6", cursor); end
        checks++; if (board[95:80] !== 16'h8001)   begin errors++; $display("FAIL ctr_down_row5: got %h, required 8001", board[95:80]); end
        do_press(1'b1, 1'b1, 1'b0);
        checks++; if (cursor !== 4'd6)             begin errors++; $display("FAIL up_down_cursor: got %0d, required 6", cursor); end
    endtask

    task automatic test_clear;
        exp_t e;
        int   nbusy;
        int   nwr;
        goto_row(7);
        checks++; if (cursor !== 4'd7) begin errors++; $display("FAIL pre_clear_cursor: got %0d, required 7", cursor); end
        e.row = -1; e.data = '0;
        @(negedge clk);
        clear_req = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        clear_req = 1'b0;
        btn_down  = 1'b1;
        nbusy = 0; nwr = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 8) btn_down = 1'b0;
            if (busy)   nbusy++;
            if (row_wr) nwr++;
            @(negedge clk);
        end
        exp_cursor = 0;
        exp_board  = '0;
        checks++; if (nbusy != ROWS)   begin errors++; $display("FAIL clear_busy_cycles: got %0d, required %0d", nbusy, ROWS); end
        checks++; if (nwr != 1)        begin errors++; $display("FAIL clear_row_wr_count: got %0d, required 1", nwr); end
        checks++; if (board !== '0)    begin errors++; $display("FAIL clear_board_final: got %h, required 0", board); end
        checks++; if (cursor !== '0)   begin errors++; $display("FAIL clear_cursor: got %0d, required 0", cursor); end
        checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_to_edit: got ready=%b busy=%b, required 0 0", ready, busy); end
    endtask

    task automatic test_reset_mid_sweep;
        goto_row(12);
        sw = 16'hFFFF;
        do_press(1'b0, 1'b0, 1'b1);
        checks++; if (board !== exp_board) begin errors++; $display("FAIL pre_sweep_board: got %h, required %h", board, exp_board); end
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy: got %b, required 1", busy); end
        checks++; if (board[12*COLS +: COLS] !== 16'hFFFF) begin errors++; $display("FAIL mid_sweep_row12: got %h, required ffff", board[12*COLS +: COLS]); end
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        checks++; if (cursor !== '0)   begin errors++; $display("FAIL rst_mid_cursor: got %0d, required 0", cursor); end
        checks++; if (board !== '0)    begin errors++; $display("FAIL rst_mid_board: got %h, required 0", board); end
        checks++; if (row_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_row_wr: got %b, required 0", row_wr); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_ready: got %b, required 1", ready); end
        exp_board  = '0;
        exp_cursor = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b, required 1", ready); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL post_rst_busy: got %b, required 0", busy); end
        checks++; if (board !== '0)   begin errors++; $display("FAIL post_rst_board: got %h, required 0", board); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_cursor();
        test_boundary();
        test_simultaneous();
        test_clear();
        test_reset_mid_sweep();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: got %0d outstanding, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_loader.md
Name: board_loader

Overview:
- Parametrised successor of the single-row switch-entry stage for the Game of Life board.
- Operator steps a row cursor with up/down buttons and commits the switch bank into the selected row with the centre button.
- Adds button synchronisation/debounce, a bulk-clear sweep, and a busy flag.
- Sits between the board I/O pins and the generation engine; the engine reads the board only while `ready` is high.

Parameters:
- ROWS, 16, board height; must be ≥2.
- COLS, 16, board width; equals the switch count.
- DB_CYCLES, 250000, consecutive stable samples required before a button edge is accepted; must be ≥1.
- RW, $clog2(ROWS), cursor width; derived, do not override.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  edit mode request; level
- btn_up  in  1  raw button; asynchronous
- btn_down  in  1  raw button; asynchronous
- btn_center  in  1  raw button; asynchronous
- clear_req  in  1  synchronous one-cycle pulse; request zeroing of the whole board
- sw  in  COLS  switch bank; bit c maps to column c
- cursor  out  RW  current row index
- board  out  ROWS*COLS  row r occupies bits [r*COLS +: COLS]
- row_wr  out  1  one-cycle pulse; asserted the cycle after any row is written
- busy  out  1  high while a clear sweep is running
- ready  out  1  high in IDLE; board is stable

Behaviour:
- Reset values:
  - cursor=0, board=0, row_wr=0, busy=0, ready=1.
  - Synchroniser FFs, debounce counters and FSM state all cleared.
- Reset asserted at any time (including mid-sweep) returns to these values immediately. No partial sweep resumes after reset.
- Button conditioning, per button:
  - 2-FF synchroniser, then a stability counter.
  - The counter resets whenever the synchronised value differs from the debounced value.
  - When the counter reaches DB_CYCLES, the debounced value takes the synchronised value.
  - A press pulse (internal, one cycle) fires on a debounced 0→1 transition.
  - Latency from raw rise to pulse is DB_CYCLES+2 clocks.
  - Releases generate nothing. Holding a button gives exactly one pulse.
- FSM states: IDLE, EDIT, CLEAR.
- IDLE:
  - ready=1; press pulses are discarded.
  - enable=1 → EDIT.
  - clear_req → CLEAR.
- EDIT:
  - ready=0.
  - centre pulse: board row[cursor] <= sw on that edge; row_wr=1 on the next cycle.
  - up pulse: cursor-1. down pulse: cursor+1.
  - Bounds follow the WRAP_EN rule below.
  - up and down pulses in the same cycle: cursor unchanged.
  - centre together with up or down: the write uses the pre-move cursor; the move then applies on the same edge.
  - enable=0 → IDLE; cursor retained.
  - clear_req → CLEAR, with priority over any pulse in that cycle; those pulses are dropped.
- CLEAR:
  - busy=1, ready=0.
  - An internal sweep index k runs 0..ROWS-1, writing row k = 0 each cycle.
  - Takes exactly ROWS cycles.
  - row_wr pulses once, the cycle after the final row is written.
  - On completion cursor=0; go to EDIT if enable=1, else IDLE.
  - Button pulses, clear_req and enable changes are ignored until completion.
- board changes only on centre writes and clear sweeps. No other path modifies it.
- row_wr never asserts in two consecutive cycles from a single event.

Optional Feature:
- Macro: WRAP_EN.
- Defined:
  - up at cursor=0 → cursor=ROWS-1.
  - down at cursor=ROWS-1 → cursor=0.
  - Non-power-of-2 ROWS wraps at ROWS-1, not at 2^RW-1.
- Undefined:
  - cursor saturates; up at 0 and down at ROWS-1 are ignored.
  - No other effect on the FSM.

Test Plan:
- Reset/debounce (ROWS=COLS=16, DB_CYCLES=4):
  - Reset, then enable=1, sw=16'hA5C3.
  - Bounce btn_center 1-0-1 at 1-cycle spacing, then hold high.
  - Required: exactly one write, board[15:0]=16'hA5C3, row_wr once, 6 clocks after the last raw edge.
- Cursor stepping:
  - 3 down presses, sw=16'h0F0F, centre.
  - Required: cursor=3, board[63:48]=16'h0F0F, all other rows 0.
- Boundary:
  - Up press at cursor=0.
  - Required: cursor=0 without WRAP_EN; cursor=15 with WRAP_EN.
  - From cursor=15, down press: cursor=15 without; cursor=0 with.
- Simultaneous:
  - At cursor=5, sw=16'h8001, centre+down debounced together.
  - Required: row 5 = 16'h8001, cursor=6.
  - up+down together: cursor unchanged.
- Clear:
  - Board partly filled, cursor=7, clear_req in EDIT.
  - Required: busy=1 for exactly 16 cycles, board=0, cursor=0, single row_wr, presses during sweep ignored.
  - Returns to EDIT.
- Reset mid-sweep:
  - Assert rst_n=0 at sweep cycle 8.
  - Required: all outputs at reset values immediately.
  - After release: IDLE, ready=1, no further writes.
